// File: rtl/dsram_pkg.sv
// Purpose: shared types and constants for the data-SRAM responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsram_pkg;

    // Responder FSM encoding; values are fixed so waveforms decode consistently.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Common byte-lane strobe patterns.
    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_WORD = 4'b1111;
    localparam logic [3:0] STRB_LO   = 4'b0011;
    localparam logic [3:0] STRB_HI   = 4'b1100;

    // The wait counter is 4 bits wide, so it can count at most 15 cycles.
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    // Store-side fields held while a request is in flight.
    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } pend_t;

    function automatic bit lat_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/data_sram_responder_be_ram_bank.sv
// Purpose: word-organised RAM, 2**ADDR_W x 32, with per-byte write enables.
// Latency: read is combinational from addr_i; writes land on the rising edge.
// Backpressure: none; always ready for a read or a write.
module be_ram_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    // Contents are deliberately not reset; software must initialise memory.
    logic [31:0] mem_q [DEPTH];

    // Byte-lane write: only enabled lanes change, the rest keep old bytes.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Single read port shared by load data and the store pre-write word.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_sram_responder.sv
// Purpose: memory-side responder of the CPU data-SRAM port with programmable wait states.
// Latency: data_ok is high LATENCY cycles after the accept edge (cycle after edge E+LATENCY-1).
// Backpressure: addr_ok low while busy, before the first post-reset edge, or while hold is high.
module data_sram_responder
    import dsram_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        hold,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    // Refuse to elaborate with a latency the 4-bit wait counter cannot express.
    if (!lat_legal(LATENCY)) begin : g_lat_chk
        $error("data_sram_responder: LATENCY must be within 1..15");
    end

    // Counter load value on accept; the WAIT state counts it down to 1.
    localparam logic [3:0] LAT_CNT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q;
    pend_t             pend_q, pend_d;
    logic [ADDR_W-1:0] pidx_q, pidx_d;
    logic              load_pend;
    logic [3:0]        ram_be;
    logic [31:0]       ram_rdata;

    // Address bits outside the word index are don't-care: byte offset and alias bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    // FSM state, wait counter and the post-reset ready flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end

    // Pending request capture; only loaded on the accept edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
            pidx_q <= '0;
        end else begin
            pend_q <= pend_d;
            pidx_q <= pidx_d;
        end
    end

    // Next-state, handshake and write-enable decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_pend = 1'b0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        ram_be    = STRB_NONE;
        unique case (state_q)
            IDLE: begin
                // hold is only honoured here; once accepted a request always completes.
                addr_ok = ready_q & ~hold;
                if (req && addr_ok) begin
                    load_pend = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_CNT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end
            end
            RESP: begin
                // Write commits on the edge closing RESP, so rdata here is the pre-write word.
                data_ok = 1'b1;
                if (pend_q.wr) begin
                    ram_be = pend_q.wstrb;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pending register next-state: capture fields on accept, otherwise hold.
    always_comb begin
        pend_d = pend_q;
        pidx_d = pidx_q;
        if (load_pend) begin
            pend_d.wr    = wr;
            pend_d.wstrb = wstrb;
            pend_d.wdata = wdata;
            pidx_d       = addr[ADDR_W+1:2];
        end
    end

    be_ram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk_i   (clk),
        .be_i    (ram_be),
        .addr_i  (pidx_q),
        .wdata_i (pend_q.wdata),
        .rdata_o (ram_rdata)
    );

    // rdata is only meaningful alongside data_ok; keep it quiet otherwise.
    assign rdata = data_ok ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
    import dsram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, req, wr, hold;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    int          sel;

    logic        req0, req1;
    logic        ao0, do0, ao1, do1;
    logic [31:0] rd0, rd1;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    assign req0    = req & (sel == 0);
    assign req1    = req & (sel == 1);
    assign addr_ok = (sel == 1) ? ao1 : ao0;
    assign data_ok = (sel == 1) ? do1 : do0;
    assign rdata   = (sel == 1) ? rd1 : rd0;

    data_sram_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk), .resetn(resetn), .req(req0), .wr(wr), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .hold(hold),
        .addr_ok(ao0), .data_ok(do0), .rdata(rd0)
    );

    data_sram_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .req(req1), .wr(wr), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .hold(hold),
        .addr_ok(ao1), .data_ok(do1), .rdata(rd1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory per instance; known marks words fully written by the bench.
    logic [31:0] mdl   [2][1024];
    bit          known [2][1024];

    typedef struct {
        logic [31:0] rd;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          acc_cyc;
    int          acc_wait;
    int          a1;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int cur_lat();
        return (sel == 1) ? 1 : 2;
    endfunction

    task automatic start(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        wr = w; wstrb = s; addr = a; wdata = d; req = 1'b1;
    endtask

    // Wait for addr_ok, take the accept edge, then push the expected response.
    task automatic wait_accept(input string tag);
        int          i;
        logic [9:0]  idx;
        exp_t        e;
        i = 0;
        #1;
        while (!addr_ok && i < 40) begin
            @(negedge clk); #1; i++;
        end
        acc_wait = i;
        check({tag, "_accept_timeout"}, 32'(i >= 40), 32'd0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        req = 1'b0;
        idx = addr[11:2];
        e.rd  = mdl[sel][idx];
        e.chk = known[sel][idx];
        sb.push_back(e);
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mdl[sel][idx][8*b +: 8] = wdata[8*b +: 8];
            if (wstrb == STRB_WORD) known[sel][idx] = 1'b1;
        end
    endtask

    // Wait for data_ok, check its latency and the scoreboard head.
    task automatic wait_resp(input string tag);
        int   i;
        exp_t e;
        i = 0;
        @(negedge clk);
        while (!data_ok && i < 40) begin
            @(negedge clk); i++;
        end
        check({tag, "_resp_timeout"}, 32'(i >= 40), 32'd0);
        check({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(cur_lat()));
        last_rd = rdata;
        check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) check({tag, "_rdata"}, rdata, e.rd);
        end
    endtask

    task automatic pulse_end(input string tag);
        @(negedge clk); #1;
        check({tag, "_pulse_dok"}, 32'(data_ok), 32'd0);
        check({tag, "_pulse_rdata"}, rdata, 32'h0);
    endtask

    task automatic txn(input string tag, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
        start(w, s, a, d);
        wait_accept(tag);
        wait_resp(tag);
        pulse_end(tag);
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        resetn = 1'b0; req = 1'b0; wr = 1'b0; hold = 1'b0;
        wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; sel = 0;
        #2;
        check("rst_addr_ok0", 32'(ao0), 32'd0);
        check("rst_data_ok0", 32'(do0), 32'd0);
        check("rst_rdata0",   rd0, 32'h0);
        check("rst_data_ok1", 32'(do1), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rdy_first_cycle", 32'(addr_ok), 32'd0);
        @(negedge clk); #1;
        check("rdy_after_edge", 32'(addr_ok), 32'd1);

        // 1. word write then read
        txn("t1_st", 1'b1, STRB_WORD, 32'h10, 32'hDEADBEEF);
        txn("t1_ld", 1'b0, STRB_NONE, 32'h10, 32'h0);
        check("t1_value", last_rd, 32'hDEADBEEF);

        // 2. byte lanes and empty strobe
        txn("t2_pre", 1'b1, STRB_WORD, 32'h10, 32'h0);
        txn("t2_b1",  1'b1, 4'b0010,   32'h10, 32'h0000AB00);
        txn("t2_b3",  1'b1, 4'b1000,   32'h10, 32'hCD000000);
        txn("t2_ld",  1'b0, STRB_NONE, 32'h10, 32'h0);
        check("t2_value", last_rd, 32'hCD00AB00);
        txn("t2_nop", 1'b1, STRB_NONE, 32'h10, 32'h12345678);
        check("t2_nop_prewrite", last_rd, 32'hCD00AB00);
        txn("t2_ld2", 1'b0, STRB_NONE, 32'h10, 32'h0);
        check("t2_unchanged", last_rd, 32'hCD00AB00);

        // 3. three-lane strobe
        txn("t3_pre", 1'b1, STRB_WORD, 32'h20, 32'h11223344);
        txn("t3_st",  1'b1, 4'b0111,   32'h20, 32'h00AABBCC);
        check("t3_prewrite", last_rd, 32'h11223344);
        txn("t3_ld",  1'b0, STRB_NONE, 32'h20, 32'h0);
        check("t3_value", last_rd, 32'h11AABBCC);

        // 4. stall, then back-to-back loads
        hold = 1'b1;
        start(1'b0, STRB_NONE, 32'h20, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("t4_hold_addr_ok", 32'(addr_ok), 32'd0);
            check("t4_hold_data_ok", 32'(data_ok), 32'd0);
        end
        hold = 1'b0;
        wait_accept("t4_rel");
        check("t4_same_cycle", 32'(acc_wait), 32'd0);
        wait_resp("t4_rel");
        check("t4_rel_value", last_rd, 32'h11AABBCC);
        pulse_end("t4_rel");
        start(1'b0, STRB_NONE, 32'h10, 32'h0);
        wait_accept("t4_a");
        a1 = acc_cyc;
        wait_resp("t4_a");
        start(1'b0, STRB_NONE, 32'h20, 32'h0);
        pulse_end("t4_a");
        wait_accept("t4_b");
        check("t4_b2b_spacing", 32'(acc_cyc - a1), 32'(cur_lat() + 1));
        wait_resp("t4_b");
        check("t4_b_value", last_rd, 32'h11AABBCC);
        pulse_end("t4_b");

        // 5. reset while a store waits
        txn("t5_pre", 1'b1, STRB_WORD, 32'h30, 32'h5555AAAA);
        start(1'b1, STRB_WORD, 32'h30, 32'hFFFFFFFF);
        wait_accept("t5_st");
        mdl[0][12] = 32'h5555AAAA;
        sb.delete();
        #1 resetn = 1'b0;
        #2 resetn = 1'b1;
        @(negedge clk); #1;
        check("t5_addr_ok_after_rel", 32'(addr_ok), 32'd0);
        check("t5_no_data_ok", 32'(data_ok), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("t5_no_data_ok_late", 32'(data_ok), 32'd0);
        end
        txn("t5_ld", 1'b0, STRB_NONE, 32'h30, 32'h0);
        check("t5_old_value", last_rd, 32'h5555AAAA);

        // 6. address wrap, then the single-cycle-latency instance
        txn("t6_wst", 1'b1, STRB_WORD, 32'h1004, 32'hA5A55A5A);
        txn("t6_wld", 1'b0, STRB_NONE, 32'h0004, 32'h0);
        check("t6_wrap_value", last_rd, 32'hA5A55A5A);
        sel = 1;
        @(negedge clk);
        txn("t6_l1_st", 1'b1, STRB_WORD, 32'h40, 32'hCAFEF00D);
        txn("t6_l1_hi", 1'b1, STRB_HI,   32'h40, 32'h12340000);
        check("t6_l1_prewrite", last_rd, 32'hCAFEF00D);
        txn("t6_l1_ld", 1'b0, STRB_NONE, 32'h40, 32'h0);
        check("t6_l1_value", last_rd, 32'h1234F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
